// File: rtl/hls_cdp_ocvt_chn_wen_ctrl_if.sv
// Channel/core bundle for the CDP output-convert wen controller.
// slave  : view taken by the controller itself.
// master : view taken by the surrounding datapath / core model.
interface hls_cdp_ocvt_chn_wen_ctrl_if #(
  parameter int IW = 32,
  parameter int OW = 16
);
  logic          chn_in_vld;
  logic          chn_in_rdy;
  logic [IW-1:0] chn_in_pd;
  logic [IW-1:0] core_in_pd;
  logic [OW-1:0] core_out_pd;
  logic          core_wen;
  logic          chn_out_vld;
  logic          chn_out_rdy;
  logic [OW-1:0] chn_out_pd;

  modport slave (
    input  chn_in_vld, chn_in_pd, core_out_pd, chn_out_rdy,
    output chn_in_rdy, core_in_pd, core_wen, chn_out_vld, chn_out_pd
  );

  modport master (
    output chn_in_vld, chn_in_pd, core_out_pd, chn_out_rdy,
    input  chn_in_rdy, core_in_pd, core_wen, chn_out_vld, chn_out_pd
  );
endinterface

// File: rtl/hls_cdp_ocvt_chn_wen_ctrl.sv
// Channel-side control for the CDP output-convert core.
// Holds one input beat, raises core_wen when a beat is held and the
// 2-entry result queue has room, and streams results out in order.
// All handshake outputs are decoded from registered state only, so there
// is no combinational path from chn_in_vld or chn_out_rdy to any output.
module hls_cdp_ocvt_chn_wen_ctrl #(
  parameter int IW = 32,
  parameter int OW = 16,
  parameter int CW = 16
) (
  input  logic                           nvdla_core_clk,
  input  logic                           nvdla_core_rst,
  hls_cdp_ocvt_chn_wen_ctrl_if.slave     io,
  output logic                           core_started,
  output logic [CW-1:0]                  stall_cnt
);

  // Saturating increment used by the debug stall counter.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    if (v == {CW{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(CW-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  logic          in_bawt;
  logic [IW-1:0] hold_pd;
  logic [1:0]    out_cnt;
  logic          rd_ptr;
  logic          wr_ptr;
  logic [OW-1:0] out_q [2];

  logic          out_room;
  logic          accept;
  logic          push;
  logic          pop;
  logic [1:0]    out_cnt_nxt;

  // Handshake decode from registered state.
  always_comb begin
    out_room       = (out_cnt < 2'd2);
    io.core_wen    = in_bawt & out_room;
    io.chn_in_rdy  = ~in_bawt | io.core_wen;
    accept         = io.chn_in_vld & io.chn_in_rdy;
    push           = io.core_wen;
    io.chn_out_vld = (out_cnt != 2'd0);
    pop            = io.chn_out_vld & io.chn_out_rdy;
    io.core_in_pd  = hold_pd;
    io.chn_out_pd  = out_q[rd_ptr];
  end

  // Queue occupancy update; simultaneous push and pop leave it unchanged.
  always_comb begin
    out_cnt_nxt = out_cnt;
    case ({push, pop})
      2'b10:   out_cnt_nxt = out_cnt + 2'd1;
      2'b01:   out_cnt_nxt = out_cnt - 2'd1;
      default: out_cnt_nxt = out_cnt;
    endcase
  end

  // Control state: held-beat flag, queue pointers/count, debug flags.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      in_bawt      <= 1'b0;
      out_cnt      <= 2'd0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      core_started <= 1'b0;
      stall_cnt    <= {CW{1'b0}};
    end else begin
      // A same-cycle accept refills the slot the core just consumed.
      if (accept) begin
        in_bawt <= 1'b1;
      end else if (io.core_wen) begin
        in_bawt <= 1'b0;
      end
      out_cnt <= out_cnt_nxt;
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (io.core_wen) begin
        core_started <= 1'b1;
      end
      if (in_bawt && !out_room) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
    end
  end

  // Payload storage; contents are don't-care until marked valid, so no reset.
  always_ff @(posedge nvdla_core_clk) begin
    if (accept) begin
      hold_pd <= io.chn_in_pd;
    end
    if (push) begin
      out_q[wr_ptr] <= io.core_out_pd;
    end
  end

endmodule

// File: tb/tb_hls_cdp_ocvt_chn_wen_ctrl.sv
// Directed bench for hls_cdp_ocvt_chn_wen_ctrl with an output scoreboard.
// The core is modelled as result = core_in_pd[15:0] + 1.
module tb_hls_cdp_ocvt_chn_wen_ctrl;
  localparam int IW = 32;
  localparam int OW = 16;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic core_started;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  hls_cdp_ocvt_chn_wen_ctrl_if #(.IW(IW), .OW(OW)) bus ();

  hls_cdp_ocvt_chn_wen_ctrl #(.IW(IW), .OW(OW), .CW(CW)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .io             (bus),
    .core_started   (core_started),
    .stall_cnt      (stall_cnt)
  );

  assign bus.core_out_pd = bus.core_in_pd[OW-1:0] + 16'd1;

  int total = 0;
  int bad   = 0;
  int n_pop = 0;
  logic acc;
  logic [OW-1:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: scoreboard handshakes at negedge, return #1 after posedge.
  task automatic cycle();
    logic [OW-1:0] e;
    @(negedge clk);
    acc = 1'b0;
    if (!rst) begin
      if (bus.chn_out_vld && bus.chn_out_rdy) begin
        n_pop++;
        total++;
        assert (sb.size() != 0) else begin
          bad++;
          $error("FAIL unexpected_out observed=0x%0h expected=none", bus.chn_out_pd);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("out_pd", {16'd0, bus.chn_out_pd}, {16'd0, e});
        end
      end
      if (bus.chn_in_vld && bus.chn_in_rdy) begin
        sb.push_back(bus.chn_in_pd[OW-1:0] + 16'd1);
        acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      cycle();
      chk("rst_in_rdy",  {31'd0, bus.chn_in_rdy},  32'd1);
      chk("rst_wen",     {31'd0, bus.core_wen},    32'd0);
      chk("rst_out_vld", {31'd0, bus.chn_out_vld}, 32'd0);
      chk("rst_started", {31'd0, core_started},    32'd0);
      chk("rst_stall",   {28'd0, stall_cnt},       32'd0);
    end
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic fill3();
    bus.chn_out_rdy = 1'b0;
    bus.chn_in_vld  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.chn_in_pd = 32'h0000_0200 + k;
      cycle();
      chk("fill_acc", {31'd0, acc}, 32'd1);
    end
    bus.chn_in_vld = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic got4;
    // T1: reset with vld asserted
    bus.chn_in_vld  = 1'b1;
    bus.chn_in_pd   = 32'hDEAD_BEEF;
    bus.chn_out_rdy = 1'b0;
    do_reset(3);
    bus.chn_in_vld = 1'b0;
    cycle();
    chk("t1_wen", {31'd0, bus.core_wen}, 32'd0);
    chk("t1_rdy", {31'd0, bus.chn_in_rdy}, 32'd1);

    // T2: single beat latency
    bus.chn_out_rdy = 1'b1;
    bus.chn_in_vld  = 1'b1;
    bus.chn_in_pd   = 32'h0000_00A5;
    cycle();
    bus.chn_in_vld = 1'b0;
    chk("t2_wen",       {31'd0, bus.core_wen},    32'd1);
    chk("t2_core_in",   bus.core_in_pd,           32'h0000_00A5);
    chk("t2_started0",  {31'd0, core_started},    32'd0);
    chk("t2_out_vld0",  {31'd0, bus.chn_out_vld}, 32'd0);
    cycle();
    chk("t2_out_vld",   {31'd0, bus.chn_out_vld}, 32'd1);
    chk("t2_out_pd",    {16'd0, bus.chn_out_pd},  32'h0000_00A6);
    chk("t2_started1",  {31'd0, core_started},    32'd1);
    chk("t2_wen_off",   {31'd0, bus.core_wen},    32'd0);
    cycle();
    chk("t2_out_vld_end", {31'd0, bus.chn_out_vld}, 32'd0);
    chk("t2_started_st",  {31'd0, core_started},    32'd1);

    // T3: streaming 100 beats
    n_pop = 0;
    for (int i = 0; i < 100; i++) begin
      if (i >= 2) chk("t3_out_vld", {31'd0, bus.chn_out_vld}, 32'd1);
      bus.chn_in_vld = 1'b1;
      bus.chn_in_pd  = $urandom;
      cycle();
      chk("t3_acc", {31'd0, acc}, 32'd1);
    end
    bus.chn_in_vld = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    chk("t3_pops",  n_pop,              32'd100);
    chk("t3_sb",    sb.size(),          32'd0);
    chk("t3_stall", {28'd0, stall_cnt}, 32'd0);

    // T4: backpressure
    do_reset(1);
    n_pop = 0;
    fill3();
    bus.chn_in_vld = 1'b1;
    bus.chn_in_pd  = 32'h0000_0203;
    chk("t4_rdy",     {31'd0, bus.chn_in_rdy},  32'd0);
    chk("t4_wen",     {31'd0, bus.core_wen},    32'd0);
    chk("t4_out_vld", {31'd0, bus.chn_out_vld}, 32'd1);
    chk("t4_stall0",  {28'd0, stall_cnt},       32'd0);
    for (int j = 1; j <= 3; j++) begin
      cycle();
      chk("t4_noacc", {31'd0, acc},            32'd0);
      chk("t4_stall", {28'd0, stall_cnt},      j);
      chk("t4_rdy_s", {31'd0, bus.chn_in_rdy}, 32'd0);
    end
    bus.chn_out_rdy = 1'b1;
    got4 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cycle();
      if (acc) begin
        got4 = 1'b1;
        bus.chn_in_vld = 1'b0;
      end
    end
    chk("t4_got4",  {31'd0, got4},      32'd1);
    chk("t4_pops",  n_pop,              32'd4);
    chk("t4_sb",    sb.size(),          32'd0);
    chk("t4_stall", {28'd0, stall_cnt}, 32'd4);

    // T5: stall counter saturation
    do_reset(1);
    n_pop = 0;
    fill3();
    for (int j = 1; j <= 20; j++) begin
      cycle();
      chk("t5_stall", {28'd0, stall_cnt}, (j > 15) ? 32'd15 : j);
    end
    bus.chn_out_rdy = 1'b1;
    for (int c = 0; c < 8; c++) cycle();
    chk("t5_pops",  n_pop,              32'd3);
    chk("t5_stall", {28'd0, stall_cnt}, 32'd15);

    // T6: reset mid-stream
    do_reset(1);
    n_pop = 0;
    fill3();
    chk("t6_full_vld", {31'd0, bus.chn_out_vld}, 32'd1);
    chk("t6_full_rdy", {31'd0, bus.chn_in_rdy},  32'd0);
    rst = 1'b1;
    cycle();
    chk("t6_out_vld", {31'd0, bus.chn_out_vld}, 32'd0);
    chk("t6_rdy",     {31'd0, bus.chn_in_rdy},  32'd1);
    chk("t6_started", {31'd0, core_started},    32'd0);
    chk("t6_wen",     {31'd0, bus.core_wen},    32'd0);
    rst = 1'b0;
    sb.delete();
    bus.chn_out_rdy = 1'b1;
    for (int c = 0; c < 5; c++) cycle();
    chk("t6_flushed", n_pop, 32'd0);
    bus.chn_in_vld = 1'b1;
    bus.chn_in_pd  = 32'h0000_0077;
    cycle();
    bus.chn_in_vld = 1'b0;
    for (int c = 0; c < 4; c++) cycle();
    chk("t6_post_pops", n_pop,     32'd1);
    chk("t6_post_sb",   sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
